// File: rtl/mmu_pkg.sv
// Shared types and default widths for the MMU page-table-walk request path.
//   ptw_issuer_state_e : issuer FSM states (IDLE -> REQ -> WAIT -> RESP -> IDLE)
//   PTW_*              : default parameter values for ptw_req_issuer / ptw_rsp_timer
package mmu_pkg;

    localparam int unsigned PTW_REQ_WIDTH      = 32;
    localparam int unsigned PTW_RSP_WIDTH      = 64;
    localparam int unsigned PTW_CNT_WIDTH      = 16;
    localparam int unsigned PTW_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } ptw_issuer_state_e;

endpackage

// File: rtl/ptw_req_issuer_timer.sv
// ptw_rsp_timer: response timeout counter for ptw_req_issuer.
// Only instantiated when PTW_ISSUER_TIMEOUT_EN is defined.
//   i_clk   in  clock
//   i_rst   in  synchronous active-high reset
//   clear   in  restart the count (issuer entering its wait state)
//   enable  in  count this cycle (issuer waiting for a response)
//   expired out high in the TIMEOUT_CYCLES-th consecutive enabled cycle
module ptw_rsp_timer
    import mmu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = PTW_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Fires in the cycle whose increment would make the count reach TIMEOUT_CYCLES,
    // so the waiter spends exactly TIMEOUT_CYCLES cycles waiting.
    assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ptw_req_issuer.sv
// ptw_req_issuer: pops page-table addresses from the MMU request FIFO one at a time, issues
// each to the memory port, waits for the PTE and hands {addr,data} to the PTW.
// Only one request is ever outstanding.
// Optional feature macro: PTW_ISSUER_TIMEOUT_EN -- response timeout via ptw_rsp_timer; a
// timed-out request completes with out_data=0, out_err=1. Without it out_err is tied 0.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   fifo_empty/push/pop/pop_data   show-ahead FIFO read side (pop suppressed while push)
//   mem_req_valid/ready/addr       memory request handshake
//   mem_rsp_valid/data             single-cycle response strobe and PTE
//   out_valid/ready/addr/data/err  result handshake to the PTW
//   busy                           transaction in flight
//   issued_cnt                     accepted memory requests (wrapping)
module ptw_req_issuer
    import mmu_pkg::*;
#(
    parameter int unsigned REQ_WIDTH      = PTW_REQ_WIDTH,
    parameter int unsigned RSP_WIDTH      = PTW_RSP_WIDTH,
    parameter int unsigned CNT_WIDTH      = PTW_CNT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = PTW_TIMEOUT_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 fifo_empty,
    input  logic                 fifo_push,
    output logic                 fifo_pop,
    input  logic [REQ_WIDTH-1:0] fifo_pop_data,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [REQ_WIDTH-1:0] mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [RSP_WIDTH-1:0] mem_rsp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REQ_WIDTH-1:0] out_addr,
    output logic [RSP_WIDTH-1:0] out_data,
    output logic                 out_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] issued_cnt
);

    ptw_issuer_state_e    state_q, state_d;
    logic [REQ_WIDTH-1:0] addr_q, addr_d;
    logic [RSP_WIDTH-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 req_hs;
    logic                 waiting;
    logic                 timed_out;

    assign req_hs  = (state_q == REQ) && mem_req_ready;
    assign waiting = (state_q == WAIT);

`ifdef PTW_ISSUER_TIMEOUT_EN
    ptw_rsp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clear  (req_hs),
        .enable (waiting),
        .expired(timed_out)
    );
`else
    assign timed_out = 1'b0;
    // Keeps the parameter referenced when the timeout is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = waiting & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        fifo_pop      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                // The FIFO ignores a pop in a push cycle, so only pop when it will be honoured.
                if (!fifo_empty && !fifo_push) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_pop_data;
                    state_d  = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response in the expiry cycle still wins.
                if (mem_rsp_valid) begin
                    data_d  = mem_rsp_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timed_out) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Never consume a FIFO entry that reset is about to abandon.
        if (i_rst) begin
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req_addr = addr_q;
    assign out_addr     = addr_q;
    assign out_data     = data_q;
    assign out_err      = err_q;
    assign busy         = (state_q != IDLE);
    assign issued_cnt   = cnt_q;

endmodule

// File: tb/tb_ptw_req_issuer.sv
// Self-checking bench for ptw_req_issuer: directed vectors with literal expectations plus a
// transaction-level model that is compared against the DUT on every cycle.
module tb_ptw_req_issuer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [31:0] fifo_pop_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [63:0] out_data;
    logic        out_err;
    logic        busy;
    logic [15:0] issued_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ptw_req_issuer #(
        .REQ_WIDTH     (32),
        .RSP_WIDTH     (64),
        .CNT_WIDTH     (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .fifo_empty   (fifo_empty),
        .fifo_push    (fifo_push),
        .fifo_pop     (fifo_pop),
        .fifo_pop_data(fifo_pop_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_err      (out_err),
        .busy         (busy),
        .issued_cnt   (issued_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Show-ahead FIFO stand-in: main pushes into q, this process applies DUT pops.
    logic [31:0] q[$];
    logic        pop_seen;

    initial begin
        fifo_empty    = 1'b1;
        fifo_pop_data = '0;
        forever begin
            @(negedge clk);
            pop_seen = fifo_pop;
            @(posedge clk);
            #1;
            if (pop_seen && q.size() != 0) void'(q.pop_front());
            #1;
            fifo_empty    = (q.size() == 0);
            fifo_pop_data = (q.size() == 0) ? 32'h0 : q[0];
        end
    end

    // Transaction model: stage 0 none, 1 address held for memory, 2 awaiting PTE,
    // 3 result offered to PTW. Advanced from bench inputs only.
    int          m_stage = 0;
    logic [31:0] m_addr  = '0;
    logic [63:0] m_data  = '0;
    logic        m_err   = 1'b0;
    logic [15:0] m_cnt   = '0;
`ifdef PTW_ISSUER_TIMEOUT_EN
    int          m_wait  = 0;
`endif
    logic        exp_pop;

    always @(negedge clk) begin
        exp_pop = !rst && (m_stage == 0) && !fifo_empty && !fifo_push;
        chk("m_fifo_pop", {63'h0, fifo_pop}, {63'h0, exp_pop});
        if (rst) begin
            m_stage = 0;
            m_addr  = '0;
            m_data  = '0;
            m_err   = 1'b0;
            m_cnt   = '0;
        end else begin
            chk("m_busy", {63'h0, busy}, {63'h0, m_stage != 0});
            chk("m_issued_cnt", {48'h0, issued_cnt}, {48'h0, m_cnt});
            chk("m_req_valid", {63'h0, mem_req_valid}, {63'h0, m_stage == 1});
            if (m_stage == 1) chk("m_req_addr", {32'h0, mem_req_addr}, {32'h0, m_addr});
            chk("m_out_valid", {63'h0, out_valid}, {63'h0, m_stage == 3});
            if (m_stage == 3) begin
                chk("m_out_addr", {32'h0, out_addr}, {32'h0, m_addr});
                chk("m_out_data", out_data, m_data);
                chk("m_out_err", {63'h0, out_err}, {63'h0, m_err});
            end
            case (m_stage)
                0: if (exp_pop) begin
                    m_addr  = fifo_pop_data;
                    m_stage = 1;
                end
                1: if (mem_req_ready) begin
                    m_cnt   = m_cnt + 16'd1;
                    m_stage = 2;
`ifdef PTW_ISSUER_TIMEOUT_EN
                    m_wait  = 0;
`endif
                end
                2: begin
                    if (mem_rsp_valid) begin
                        m_data  = mem_rsp_data;
                        m_err   = 1'b0;
                        m_stage = 3;
                    end
`ifdef PTW_ISSUER_TIMEOUT_EN
                    else begin
                        m_wait++;
                        if (m_wait == TO) begin
                            m_data  = '0;
                            m_err   = 1'b1;
                            m_stage = 3;
                        end
                    end
`endif
                end
                3: if (out_ready) m_stage = 0;
                default: m_stage = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        q.push_back(a);
    endtask

    // Starts in the pop cycle; needs mem_req_ready=1 and out_ready=1.
    task automatic finish_txn(input logic [31:0] a, input logic [63:0] d, input logic [15:0] c);
        tick();
        @(negedge clk);
        chk("req_valid", {63'h0, mem_req_valid}, 64'h1);
        chk("req_addr", {32'h0, mem_req_addr}, {32'h0, a});
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        @(negedge clk);
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        @(negedge clk);
        chk("out_valid", {63'h0, out_valid}, 64'h1);
        chk("out_addr", {32'h0, out_addr}, {32'h0, a});
        chk("out_data", out_data, d);
        chk("out_err", {63'h0, out_err}, 64'h0);
        chk("issued_cnt", {48'h0, issued_cnt}, {48'h0, c});
        tick();
        @(negedge clk);
        chk("idle_after_out", {62'h0, out_valid, busy}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        fifo_push     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        out_ready     = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_valids", {61'h0, fifo_pop, mem_req_valid, out_valid}, 64'h0);
        chk("rst_out_addr", {32'h0, out_addr}, 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_err", {63'h0, out_err}, 64'h0);
        chk("rst_issued_cnt", {48'h0, issued_cnt}, 64'h0);

        // 1: minimum-latency transaction
        tick();
        push(32'h1000);
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        @(negedge clk);
        chk("t1_pop", {63'h0, fifo_pop}, 64'h1);
        finish_txn(32'h1000, 64'h00AB, 16'd1);

        // 2: push blocks pop for three cycles
        tick();
        fifo_push = 1'b1;
        push(32'h2000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_no_pop", {63'h0, fifo_pop}, 64'h0);
            tick();
        end
        fifo_push = 1'b0;
        @(negedge clk);
        chk("t2_pop", {63'h0, fifo_pop}, 64'h1);
        finish_txn(32'h2000, 64'h2222_0000_0000_2222, 16'd2);

        // 3: memory back-pressure for five cycles
        tick();
        mem_req_ready = 1'b0;
        push(32'h3000);
        @(negedge clk);
        chk("t3_pop", {63'h0, fifo_pop}, 64'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("t3_req_hold", {31'h0, mem_req_valid, mem_req_addr}, {31'h0, 1'b1, 32'h3000});
            chk("t3_cnt_hold", {48'h0, issued_cnt}, 64'd2);
        end
        tick();
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t3_req_accept", {63'h0, mem_req_valid}, 64'h1);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h3333;
        @(negedge clk);
        chk("t3_cnt_once", {48'h0, issued_cnt}, 64'd3);
        tick();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t3_out", {out_addr, out_data[31:0]}, {32'h3000, 32'h3333});
        tick();

        // 4: PTW back-pressure, two queued entries drain in order
        out_ready = 1'b0;
        push(32'h4000);
        push(32'h4008);
        @(negedge clk);
        chk("t4_pop0", {63'h0, fifo_pop}, 64'h1);
        tick();
        @(negedge clk);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h44;
        @(negedge clk);
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            @(negedge clk);
            chk("t4_out_hold", {31'h0, out_valid, out_addr}, {31'h0, 1'b1, 32'h4000});
            chk("t4_data_hold", out_data, 64'h44);
            chk("t4_no_pop", {63'h0, fifo_pop}, 64'h0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_out_accept", {63'h0, out_valid}, 64'h1);
        tick();
        @(negedge clk);
        chk("t4_pop1", {62'h0, fifo_pop, busy}, 64'h2);
        finish_txn(32'h4008, 64'h88, 16'd5);

        // 5: reset while waiting, stale response afterwards
        tick();
        push(32'h5000);
        @(negedge clk);
        chk("t5_pop", {63'h0, fifo_pop}, 64'h1);
        tick();
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_no_pop_in_rst", {63'h0, fifo_pop}, 64'h0);
        tick();
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h5555;
        @(negedge clk);
        chk("t5_rst_flags", {60'h0, busy, fifo_pop, mem_req_valid, out_valid}, 64'h0);
        chk("t5_rst_out", {out_addr, out_data[31:0]}, 64'h0);
        chk("t5_rst_err", {63'h0, out_err}, 64'h0);
        chk("t5_rst_cnt", {48'h0, issued_cnt}, 64'h0);
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_ignored", {62'h0, out_valid, busy}, 64'h0);
            tick();
        end

        // 6: no response at all
        push(32'h6000);
        @(negedge clk);
        chk("t6_pop", {63'h0, fifo_pop}, 64'h1);
        tick();
        @(negedge clk);
        for (int i = 0; i < TO; i++) begin
            tick();
            @(negedge clk);
            chk("t6_waiting", {62'h0, out_valid, busy}, 64'h1);
        end
        tick();
`ifdef PTW_ISSUER_TIMEOUT_EN
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hBAD;
        @(negedge clk);
        chk("t6_to_valid", {62'h0, out_valid, out_err}, 64'h3);
        chk("t6_to_data", out_data, 64'h0);
        chk("t6_to_addr", {32'h0, out_addr}, 64'h6000);
        tick();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t6_late_ignored", {62'h0, out_valid, busy}, 64'h0);
`else
        @(negedge clk);
        chk("t6_still_wait", {61'h0, out_valid, busy, out_err}, 64'h2);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hBAD;
        @(negedge clk);
        tick();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t6_late_rsp", {62'h0, out_valid, out_err}, 64'h2);
        chk("t6_late_data", out_data, 64'hBAD);
        tick();
        @(negedge clk);
        chk("t6_done", {63'h0, busy}, 64'h0);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
